// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port-B arbiter: FSM states,
// owner encodings and the default starvation bound.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/bram_arb_age_ctr.sv
// Saturating starvation counter: counts CPU wins taken over a pending
// requester 1, saturates at MAX_WAIT, clear has priority over increment.
module bram_arb_age_ctr
  import bram_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic       at_max,
  output logic [3:0] cnt
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != MAX_W)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_W);
  assign cnt    = cnt_q;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port B between the CPU (requester 0) and a secondary DMA
// requester (1): fixed CPU priority with a starvation bound for requester 1.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [3:0]        dbg_age_cnt
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds
  // them until it sees a one-cycle gnt; it may drop req at the edge ending
  // gnt. Reads return rvalid (with rdata) exactly one cycle after gnt.
  // Dropping req before gnt withdraws it.

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, mem_we_q, busy_q;
  logic                gnt0_d, gnt1_d, rvalid0_d, rvalid1_d, mem_we_d, busy_d;
  logic                age_inc, age_clr, age_at_max, pick_dma;
  logic [3:0]          age_cnt;

  bram_arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (age_inc),
    .clr    (age_clr),
    .at_max (age_at_max),
    .cnt    (age_cnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    age_inc    = 1'b0;
    age_clr    = 1'b0;
    pick_dma   = req1 && (!req0 || age_at_max);
    unique case (state_q)
      IDLE: begin
        // The age counter only moves on decisions made here, so a req1 that
        // comes and goes while an access is in flight never ages.
        age_clr = !req1 || pick_dma;
        if (req0 || req1) begin
          age_inc    = !pick_dma && req1;
          owner_d    = pick_dma ? OWN_DMA : OWN_CPU;
          we_d       = pick_dma ? we1 : we0;
          mem_addr_d = pick_dma ? addr1 : addr0;
          mem_din_d  = pick_dma ? wdata1 : wdata0;
          state_d    = ISSUE;
        end
      end
      ISSUE:   state_d = we_q ? IDLE : RDWAIT;
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    gnt0_d    = (state_d == ISSUE)  && (owner_d == OWN_CPU);
    gnt1_d    = (state_d == ISSUE)  && (owner_d == OWN_DMA);
    rvalid0_d = (state_d == RDWAIT) && (owner_d == OWN_CPU);
    rvalid1_d = (state_d == RDWAIT) && (owner_d == OWN_DMA);
    mem_we_d  = (state_d == ISSUE)  && we_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rvalid0_q ? mem_dout : '0;
  assign rdata1      = rvalid1_q ? mem_dout : '0;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;
  assign dbg_age_cnt = age_cnt;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 1-cycle BRAM.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [15:0] rdata0, rdata1, mem_addr, mem_din;
  logic [15:0] mem_dout = '0;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_age_cnt;

  logic [15:0] bram [0:65535];
  logic [0:0]  exp_q[$];
  logic [3:0]  exp_age_q[$];

  int tests_run = 0;
  int fails = 0;

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy),
    .dbg_state(dbg_state), .dbg_age_cnt(dbg_age_cnt)
  );

  // clock / BRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  // driver tasks (drive on the falling edge, sample before driving)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic test_reset();
    tick();
    tests_run++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_we, busy} !== 6'b0 || rdata0 !== 16'h0 ||
        rdata1 !== 16'h0 || mem_addr !== 16'h0 || mem_din !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: ctl=%b rdata0=%h rdata1=%h addr=%h din=%h, want all 0",
               {gnt0, gnt1, rvalid0, rvalid1, mem_we, busy}, rdata0, rdata1, mem_addr, mem_din);
    end
    tests_run++;
    if (dbg_state !== 2'(IDLE) || dbg_age_cnt !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: state=%0d age=%0d, want 0 0", dbg_state, dbg_age_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    drive0(1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    tests_run++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 16'h0010 || mem_we !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL cpu_read_gnt: gnt0=%b gnt1=%b addr=%h we=%b busy=%b, want 1 0 0010 0 1",
               gnt0, gnt1, mem_addr, mem_we, busy);
    end
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tests_run++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF || rvalid1 !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_data: rvalid0=%b rdata0=%h rvalid1=%b gnt0=%b gnt1=%b, want 1 beef 0 0 0",
               rvalid0, rdata0, rvalid1, gnt0, gnt1);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0 || rvalid0 !== 1'b0 || rdata0 !== 16'h0 || dbg_state !== 2'(IDLE)) begin
      fails++;
      $display("FAIL cpu_read_idle: busy=%b rvalid0=%b rdata0=%h state=%0d, want 0 0 0000 0",
               busy, rvalid0, rdata0, dbg_state);
    end
  endtask

  task automatic test_dma_write();
    drive1(1'b1, 1'b1, 16'h0020, 16'h1234);
    tick();
    tests_run++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_din !== 16'h1234) begin
      fails++;
      $display("FAIL dma_write_gnt: gnt1=%b gnt0=%b we=%b addr=%h din=%h, want 1 0 1 0020 1234",
               gnt1, gnt0, mem_we, mem_addr, mem_din);
    end
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tests_run++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0020 || mem_din !== 16'h1234 || rvalid1 !== 1'b0) begin
      fails++;
      $display("FAIL dma_write_done: busy=%b we=%b addr=%h din=%h rvalid1=%b, want 0 0 0020 1234 0",
               busy, mem_we, mem_addr, mem_din, rvalid1);
    end
    drive0(1'b1, 1'b0, 16'h0020, 16'h0);
    tick();
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tests_run++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'h1234) begin
      fails++;
      $display("FAIL dma_write_readback: rvalid0=%b rdata0=%h, want 1 1234", rvalid0, rdata0);
    end
    tick();
  endtask

  task automatic test_contention();
    int got = 0;
    logic [0:0] e;
    logic [3:0] ea;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back(1'b0);
        exp_age_q.push_back(4'(j + 1));
      end
      exp_q.push_back(1'b1);
      exp_age_q.push_back(4'd0);
    end
    drive0(1'b1, 1'b1, 16'h0100, 16'hAAAA);
    drive1(1'b1, 1'b1, 16'h0200, 16'h5555);
    for (int i = 0; i < 40 && got < 10; i++) begin
      tick();
      if (gnt0 && gnt1) begin
        tests_run++;
        fails++;
        $display("FAIL contention_both: gnt0=1 gnt1=1, want at most one");
      end
      if (gnt0 || gnt1) begin
        e  = exp_q.pop_front();
        ea = exp_age_q.pop_front();
        tests_run++;
        if (gnt1 !== e) begin
          fails++;
          $display("FAIL contention_winner[%0d]: gnt1=%b, want %b", got, gnt1, e);
        end
        tests_run++;
        if (dbg_age_cnt !== ea) begin
          fails++;
          $display("FAIL contention_age[%0d]: age=%0d, want %0d", got, dbg_age_cnt, ea);
        end
        got++;
      end
    end
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    tests_run++;
    if (got != 10) begin
      fails++;
      $display("FAIL contention_timeout: grants=%0d, want 10", got);
    end
    exp_q.delete();
    exp_age_q.delete();
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    bram[16'h0033] = 16'hC0DE;
    drive0(1'b1, 1'b0, 16'h0010, 16'h0);
    drive1(1'b1, 1'b0, 16'h0033, 16'h0);
    tick();
    tests_run++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || dbg_age_cnt !== 4'd1) begin
      fails++;
      $display("FAIL simul_first: gnt0=%b gnt1=%b age=%0d, want 1 0 1", gnt0, gnt1, dbg_age_cnt);
    end
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    tick();
    tests_run++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_addr !== 16'h0033 || dbg_age_cnt !== 4'd0) begin
      fails++;
      $display("FAIL simul_second: gnt1=%b gnt0=%b addr=%h age=%0d, want 1 0 0033 0",
               gnt1, gnt0, mem_addr, dbg_age_cnt);
    end
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tests_run++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'hC0DE || rvalid0 !== 1'b0 || rdata0 !== 16'h0) begin
      fails++;
      $display("FAIL simul_data: rvalid1=%b rdata1=%h rvalid0=%b rdata0=%h, want 1 c0de 0 0000",
               rvalid1, rdata1, rvalid0, rdata0);
    end
    tick();
  endtask

  task automatic test_withdrawal();
    int seen = 0;
    drive0(1'b1, 1'b1, 16'h0040, 16'h7777);
    tick();
    tests_run++;
    if (gnt0 !== 1'b1 || dbg_state !== 2'(ISSUE)) begin
      fails++;
      $display("FAIL withdraw_issue: gnt0=%b state=%0d, want 1 1", gnt0, dbg_state);
    end
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    drive1(1'b1, 1'b0, 16'h0050, 16'h0);
    tick();
    drive1(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt1 || rvalid1) seen++;
    end
    tests_run++;
    if (seen != 0 || dbg_age_cnt !== 4'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL withdraw_nogrant: dma_events=%0d age=%0d busy=%b, want 0 0 0", seen, dbg_age_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    drive0(1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tests_run++;
    if (dbg_state !== 2'(RDWAIT) || rvalid0 !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: state=%0d rvalid0=%b, want 2 1", dbg_state, rvalid0);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_we, busy} !== 6'b0 || rdata0 !== 16'h0 ||
        mem_addr !== 16'h0 || mem_din !== 16'h0 || dbg_state !== 2'(IDLE)) begin
      fails++;
      $display("FAIL rst_mid_outputs: ctl=%b rdata0=%h addr=%h din=%h state=%0d, want all 0",
               {gnt0, gnt1, rvalid0, rvalid1, mem_we, busy}, rdata0, mem_addr, mem_din, dbg_state);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (rvalid0 || rvalid1 || busy) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_mid_quiet: events=%0d, want 0", seen);
    end
    drive0(1'b1, 1'b0, 16'h0010, 16'h0);
    tick();
    tests_run++;
    if (gnt0 !== 1'b1 || mem_addr !== 16'h0010) begin
      fails++;
      $display("FAIL rst_mid_regnt: gnt0=%b addr=%h, want 1 0010", gnt0, mem_addr);
    end
    drive0(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tests_run++;
    if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin
      fails++;
      $display("FAIL rst_mid_redata: rvalid0=%b rdata0=%h, want 1 beef", rvalid0, rdata0);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) bram[i] = 16'h0;
    bram[16'h0010] = 16'hBEEF;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_contention();
    test_simultaneous();
    test_withdrawal();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
